uart_trx: RTL and testbench

- 8N1 UART transceiver for the 50 MHz system clock domain. Default rate is 115200 baud.
- Receiver: deserialises the `rx` line and flags frame completion and stop-bit errors.
- Transmitter: serialises a byte on request.
- Sits between the board UART pins and the register/bus logic; both directions share one baud divider constant.

---
 rtl/uart_trx.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_trx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_trx.sv
// 8N1 UART transceiver; RX and TX share one integer baud divider.
// Optional build macro UART_LOOPBACK_EN adds a loopback input routing tx into the receiver.
`timescale 1ns / 1ps
module uart_trx #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
`ifdef UART_LOOPBACK_EN
  input  logic       loopback,
`endif
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_error,
  output logic       rx_idle,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_idle
);

  localparam int unsigned BitCycles  = CLK_FREQ_HZ / BAUD;
  localparam int unsigned HalfCycles = BitCycles / 2;
  localparam int unsigned StopCycles = BitCycles + HalfCycles;
  localparam int unsigned CntW       = $clog2(StopCycles + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t BitLast  = cnt_t'(BitCycles - 1);
  localparam cnt_t HalfLast = cnt_t'(HalfCycles - 1);
  localparam cnt_t HalfCnt  = cnt_t'(HalfCycles);
  localparam cnt_t StopLast = cnt_t'(StopCycles - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  rx_state_e  rx_state_q, rx_state_d;
  cnt_t       rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_ready_q, rx_ready_d;
  logic       rx_error_q, rx_error_d;
  logic       stop_err_q, stop_err_d;
  logic       rx_meta_q, rx_sync_q;
  logic       rx_src;

  tx_state_e  tx_state_q, tx_state_d;
  cnt_t       tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_q, tx_d;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_q : rx;
`else
  assign rx_src = rx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_src;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
      rx_error_q <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
      rx_error_q <= rx_error_d;
      stop_err_q <= stop_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_ready_d = rx_ready_q;
    rx_error_d = rx_error_q;
    stop_err_d = stop_err_q;
    case (rx_state_q)
      RxIdle: begin
        if (!rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
          rx_ready_d = 1'b0;
          rx_error_d = 1'b0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
            stop_err_d = 1'b0;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        // Watch from the nominal start of the stop bit so short glitches anywhere in it count.
        if (rx_cnt_q >= HalfCnt && rx_cnt_q < StopLast && !rx_sync_q) begin
          stop_err_d = 1'b1;
        end
        if (rx_cnt_q == StopLast) begin
          rx_cnt_d   = '0;
          rx_data_d  = rx_shift_q;
          rx_ready_d = 1'b1;
          rx_error_d = stop_err_q;
          rx_state_d = RxIdle;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TxIdle: begin
        tx_d = 1'b1;
        if (tx_start) begin
          tx_shift_d = tx_data;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TxStop;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_state_d = TxIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign rx_data  = rx_data_q;
  assign rx_ready = rx_ready_q;
  assign rx_error = rx_error_q;
  assign rx_idle  = (rx_state_q == RxIdle);
  assign tx       = tx_q;
  assign tx_idle  = (tx_state_q == TxIdle);

endmodule

// File: tb/tb_uart_trx.sv
// Randomised self-checking bench for uart_trx: frames are driven/observed as line waveforms
// and compared with the bytes and flags they should carry.
`timescale 1ns / 1ps
module tb_uart_trx;

  localparam int Bit  = 434;
  localparam int Cap  = 4600;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, rx_error, rx_idle;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx, tx_idle;
`ifdef UART_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  uart_trx dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
`ifdef UART_LOOPBACK_EN
    .loopback (loopback),
`endif
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_error (rx_error),
    .rx_idle  (rx_idle),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx       (tx),
    .tx_idle  (tx_idle)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame on rx; optional 2-cycle low glitch ~2 us into the stop bit.
  task automatic send_rx(input logic [7:0] b, input bit glitch);
    rx = 1'b0;
    wait_cyc(Bit);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      wait_cyc(Bit);
    end
    rx = 1'b1;
    if (glitch) begin
      wait_cyc(100);
      rx = 1'b0;
      wait_cyc(2);
      rx = 1'b1;
      wait_cyc(Bit - 102);
    end else begin
      wait_cyc(Bit);
    end
  endtask

  task automatic rx_frame_check(input logic [7:0] b, input bit glitch);
    send_rx(b, glitch);
    wait_cyc(100);
    check("rx_data", {24'h0, rx_data}, {24'h0, b});
    check("rx_ready", {31'h0, rx_ready}, 32'd1);
    check("rx_error", {31'h0, rx_error}, {31'h0, glitch});
    check("rx_idle", {31'h0, rx_idle}, 32'd1);
  endtask

  // Request a byte and record the line; optionally retry mid-frame with 0xFF.
  task automatic run_tx(input logic [7:0] b, input bit poke);
    bit         line_s [Cap];
    bit         idle_s [Cap];
    int         busy;
    logic [9:0] frame;
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int i = 0; i < Cap; i++) begin
      line_s[i] = tx;
      idle_s[i] = tx_idle;
      if (poke && i == 1500) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
      end else if (poke && i == 1501) begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    frame = {1'b1, b, 1'b0};
    busy  = 0;
    for (int i = 0; i < Cap; i++) if (!idle_s[i]) busy++;
    check("tx_busy_cycles", busy, 10 * Bit);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d", k), {31'h0, line_s[Bit / 2 + Bit * k]}, {31'h0, frame[k]});
    end
    check("tx_line_after", {31'h0, line_s[Cap - 1]}, 32'd1);
    check("tx_idle_after", {31'h0, idle_s[Cap - 1]}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_idle"}, {31'h0, rx_idle}, 32'd1);
    check({tag, "_rx_ready"}, {31'h0, rx_ready}, 32'd0);
    check({tag, "_rx_error"}, {31'h0, rx_error}, 32'd0);
    check({tag, "_rx_data"}, {24'h0, rx_data}, 32'd0);
    check({tag, "_tx"}, {31'h0, tx}, 32'd1);
    check({tag, "_tx_idle"}, {31'h0, tx_idle}, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    bit         g;

    rst = 1'b1;
    rx  = 1'b0;
    wait_cyc(50);
    rst = 1'b0;
    rx  = 1'b1;
    wait_cyc(5);
    check_reset_state("reset");

    rx_frame_check(8'hAA, 1'b0);
    rx_frame_check(8'h55, 1'b1);

    // A new start edge clears both flags; released early it is a false start.
    rx = 1'b0;
    wait_cyc(5);
    check("flags_clr_ready", {31'h0, rx_ready}, 32'd0);
    check("flags_clr_error", {31'h0, rx_error}, 32'd0);
    check("flags_clr_idle", {31'h0, rx_idle}, 32'd0);
    rx = 1'b1;
    wait_cyc(300);
    check("short_low_idle", {31'h0, rx_idle}, 32'd1);
    check("short_low_data", {24'h0, rx_data}, 32'h55);

    // 2 us false start.
    rx = 1'b0;
    wait_cyc(50);
    check("false_start_busy", {31'h0, rx_idle}, 32'd0);
    wait_cyc(50);
    rx = 1'b1;
    wait_cyc(150);
    check("false_start_idle", {31'h0, rx_idle}, 32'd1);
    check("false_start_ready", {31'h0, rx_ready}, 32'd0);
    wait_cyc(50);

    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom_range(0, 255));
      g = 1'($urandom_range(0, 1));
      rx_frame_check(b, g);
      wait_cyc(20 + $urandom_range(0, 200));
    end

    run_tx(8'h3C, 1'b1);
    for (int n = 0; n < 2; n++) begin
      b = 8'($urandom_range(0, 255));
      run_tx(b, 1'b0);
    end

    // Reset in the middle of an RX frame and a TX frame.
    rx_frame_check(8'hC3, 1'b0);
    @(negedge clk);
    tx_data  = 8'h81;
    tx_start = 1'b1;
    rx       = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    wait_cyc(1000);
    check("mid_tx_busy", {31'h0, tx_idle}, 32'd0);
    check("mid_rx_busy", {31'h0, rx_idle}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midreset");
    rx = 1'b1;
    wait_cyc(600);

`ifdef UART_LOOPBACK_EN
    loopback = 1'b1;
    rx       = 1'b0;
    run_tx(8'hA5, 1'b0);
    check("lb_rx_data", {24'h0, rx_data}, 32'hA5);
    check("lb_rx_ready", {31'h0, rx_ready}, 32'd1);
    check("lb_rx_error", {31'h0, rx_error}, 32'd0);
    @(negedge clk);
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_cyc(1500);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("lb_midreset");
    loopback = 1'b0;
    rx       = 1'b1;
    wait_cyc(600);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
